mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 55 +++++
 rtl/mem_lsu_load_align.sv | 27 ++
 rtl/mem_lsu.sv | 145 ++++++++++++++
 tb/tb_mem_lsu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: write-flag codes, access size
// codes, FSM state encodings and the small lane/strobe helper functions.
package mem_lsu_pkg;

  // Direction of a latched access
  localparam logic WE_LOAD  = 1'b0;
  localparam logic WE_STORE = 1'b1;

  // Access size codes; 2'b11 is not a legal size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Load/store FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // True when the size is legal and the address is naturally aligned for it
  function automatic logic lsu_access_ok(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~lane[0];
      SZ_W:    ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane write enables for a store of the given size at the given lane
  function automatic logic [3:0] lsu_wstrb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << lane;
      SZ_H:    strb = lane[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Store data replicated so the addressed lanes carry the operand
  function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      SZ_B:    wd = {4{data[7:0]}};
      SZ_H:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Picks the addressed byte/half out of the raw RAM word and sign- or
// zero-extends it to 32 bits for write-back.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by extension according to size and signedness
  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_B:    o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_H:    o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Accepts one access from EX/MEM, issues a single
// request to the data RAM, waits for ack (or gives up after TIMEOUT cycles),
// and presents aligned load data for write-back while stalling the pipeline.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] alu_c_i,
  input  logic [31:0] rs2_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] dram_rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        err_o
);

  // Counter value seen in the last WAIT cycle before the access is abandoned
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  lsu_state_e  r_state;
  lsu_state_e  w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_unsigned;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_access;
  logic        w_ok;
  logic        w_start;
  logic        w_misalign;
  logic        w_in_wait;
  logic        w_timeout;
  logic [31:0] w_load_data;

  // Reset is folded in so the combinational flags read zero while held in reset
  assign w_access   = rst_n_i & valid_i & (mem_re_i | mem_we_i);
  assign w_ok       = lsu_access_ok(mem_size_i, alu_c_i[1:0]);
  assign w_start    = (r_state == ST_IDLE) & w_access & w_ok;
  assign w_misalign = (r_state == ST_IDLE) & w_access & ~w_ok;
  assign w_in_wait  = (r_state == ST_WAIT);
  assign w_timeout  = w_in_wait & ~bus_ack_i & (r_cnt == LP_LAST_WAIT);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: start an access, wait for ack or timeout, spend one cycle in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_WAIT;
      ST_WAIT: if (bus_ack_i || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: request only in WAIT, stall from the start cycle through WAIT
  always_comb begin
    bus_req_o  = w_in_wait;
    stall_o    = w_start | w_in_wait;
    misalign_o = w_misalign;
  end

  // Latch the access on start so the bus sees stable values through WAIT
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_we       <= WE_LOAD;
      r_size     <= SZ_B;
      r_lane     <= '0;
      r_unsigned <= 1'b0;
    end else if (w_start) begin
      r_addr     <= {alu_c_i[31:2], 2'b00};
      r_wdata    <= lsu_wdata(mem_size_i, rs2_data_i);
      r_wstrb    <= mem_we_i ? lsu_wstrb(mem_size_i, alu_c_i[1:0]) : 4'b0000;
      r_we       <= mem_we_i ? WE_STORE : WE_LOAD;
      r_size     <= mem_size_i;
      r_lane     <= alu_c_i[1:0];
      r_unsigned <= mem_unsigned_i;
    end
  end

  // WAIT-cycle counter, cleared whenever the FSM is not waiting
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                   r_cnt <= '0;
    else if (w_in_wait && !bus_ack_i && !w_timeout) r_cnt <= r_cnt + 8'd1;
    else                                            r_cnt <= '0;
  end

  // Timeout pulse and load result; stores leave the held load data untouched
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_err <= w_timeout;
      if (w_in_wait && (r_we == WE_LOAD)) begin
        if (bus_ack_i)      r_rdata <= w_load_data;
        else if (w_timeout) r_rdata <= '0;
      end
    end
  end

  lsu_load_align u_align (
    .i_rdata    (bus_rdata_i),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  assign bus_we_o     = r_we;
  assign bus_addr_o   = r_addr;
  assign bus_wdata_o  = r_wdata;
  assign bus_wstrb_o  = r_wstrb;
  assign dram_rdata_o = r_rdata;
  assign err_o        = r_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a driver issues accesses and pushes the
// expected bus transaction and result, a bus responder acks after a planned
// number of WAIT cycles, and a monitor pops and compares on each DUT event.
module tb_mem_lsu;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i, mem_re_i, mem_we_i, mem_unsigned_i;
  logic [1:0]  mem_size_i;
  logic [31:0] alu_c_i, rs2_data_i;
  logic        bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i, dram_rdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        stall_o, misalign_o, err_o;

  typedef struct {
    bit          isMis;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  int          doneCount = 0;
  int          ackAt = 0;
  logic [31:0] respData = '0;
  bit          lateAck = 1'b0;
  logic [31:0] modelRdata = '0;

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .alu_c_i(alu_c_i), .rs2_data_i(rs2_data_i), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .dram_rdata_o(dram_rdata_o), .stall_o(stall_o), .misalign_o(misalign_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: loaded value from the raw word using plain shift/mask arithmetic
  function automatic logic [31:0] refLoad(input logic [31:0] word, input int lane, input int bytes, input bit uns);
    longint raw, m, v;
    int bits;
    bits = 8 * bytes;
    raw  = longint'(word) >> (8 * lane);
    m    = (longint'(1) << bits) - 1;
    v    = raw & m;
    if (!uns && bits < 32 && ((v >> (bits - 1)) & 1) == 1) v = v | ~m;
    return 32'(v);
  endfunction

  // Reference: full expected outcome of one access
  task automatic buildExpect(input bit re, we, input logic [1:0] sz, input bit uns,
                             input logic [31:0] addr, rs2, input int ack,
                             input logic [31:0] rdat, output exp_t e);
    int bytes, lane;
    bit timedOut;
    longint wd, m;
    bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane  = int'(addr % 4);
    e = '{isMis: 1'b0, addr: '0, we: 1'b0, wstrb: '0, wdata: '0, err: 1'b0, rdata: '0, stall: 0};
    if (sz == 2'd3 || (addr % bytes) != 0) begin
      e.isMis = 1'b1;
      return;
    end
    timedOut = !(ack >= 1 && ack <= TO);
    e.addr  = addr & 32'hFFFF_FFFC;
    e.we    = we;
    e.err   = timedOut;
    e.stall = 1 + (timedOut ? TO : ack);
    if (we) begin
      m  = (longint'(1) << (8 * bytes)) - 1;
      wd = 0;
      for (int i = 0; i < 4 / bytes; i++) wd = wd | ((longint'(rs2) & m) << (8 * bytes * i));
      e.wdata = 32'(wd);
      e.wstrb = 4'(((1 << bytes) - 1) << lane);
    end else begin
      e.wstrb = 4'b0000;
      modelRdata = timedOut ? 32'h0 : refLoad(rdat, lane, bytes, uns);
    end
    e.rdata = modelRdata;
  endtask

  // Present one access for a cycle, queueing its expectation when it is real
  task automatic issueOnly(input bit v, re, we, input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, rs2, input int ack,
                           input logic [31:0] rdat, output bit access);
    exp_t e;
    access   = v && (re || we);
    ackAt    = ack;
    respData = rdat;
    if (access) begin
      buildExpect(re, we, sz, uns, addr, rs2, ack, rdat, e);
      sb.push_back(e);
    end
    valid_i = v; mem_re_i = re; mem_we_i = we; mem_size_i = sz;
    mem_unsigned_i = uns; alu_c_i = addr; rs2_data_i = rs2;
    @(posedge clk_i); #1;
    valid_i = 1'b0; mem_re_i = 1'($urandom); mem_we_i = 1'($urandom);
    alu_c_i = $urandom; rs2_data_i = $urandom;
  endtask

  task automatic applyStimulus(input bit v, re, we, input logic [1:0] sz, input bit uns,
                               input logic [31:0] addr, rs2, input int ack,
                               input logic [31:0] rdat);
    bit access;
    int start;
    start = doneCount;
    issueOnly(v, re, we, sz, uns, addr, rs2, ack, rdat, access);
    if (!access) begin
      repeat (2) begin @(posedge clk_i); #1; end
    end else begin
      for (int i = 0; i < 20 && doneCount == start; i++) begin @(posedge clk_i); #1; end
      if (doneCount == start) begin
        nCompared++; nMismatched++;
        $display("[TB] FAIL done_wait: no completion within 20 cycles, expected one (addr 0x%08h)", addr);
        sb.delete();
      end
    end
  endtask

  // Reset in the middle of WAIT, then a late ack that must be ignored
  task automatic resetMidWait();
    bit access;
    issueOnly(1, 1, 0, 2'b10, 0, 32'h500, 0, 0, 32'h0, access);
    @(posedge clk_i); #3;
    rst_n_i = 1'b0;
    #1;
    checkOutput("rst_bus_req", 32'(bus_req_o), 0);
    checkOutput("rst_stall", 32'(stall_o), 0);
    checkOutput("rst_err", 32'(err_o), 0);
    checkOutput("rst_dram", dram_rdata_o, 0);
    sb.delete();
    modelRdata = '0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    lateAck = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("late_ack_req", 32'(bus_req_o), 0);
    lateAck = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("late_ack_dram", dram_rdata_o, 0);
    checkOutput("late_ack_stall", 32'(stall_o), 0);
  endtask

  // Bus responder: ack on the planned WAIT cycle, stray acks while idle
  int waitCnt = 0;
  always begin
    @(posedge clk_i); #1;
    if (!rst_n_i || !bus_req_o) begin
      waitCnt     = 0;
      bus_ack_i   = lateAck | ($urandom_range(0, 3) == 0);
      bus_rdata_i = $urandom;
    end else begin
      waitCnt++;
      if (ackAt != 0 && waitCnt == ackAt) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = respData;
      end else begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on misalign pulses and DONE cycles
  bit          prevReq = 1'b0;
  int          stallRun = 0;
  logic [31:0] holdRdata = '0;
  exp_t        cur;
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      prevReq = 1'b0; stallRun = 0; holdRdata = '0;
    end else begin
      if (stall_o) stallRun++;
      if (misalign_o) begin
        if (sb.size() == 0 || !sb[0].isMis) begin
          nCompared++; nMismatched++;
          $display("[TB] FAIL misalign_unexpected: got pulse, expected none");
        end else begin
          cur = sb.pop_front();
          checkOutput("misalign_stall", 32'(stall_o), 0);
          checkOutput("misalign_req", 32'(bus_req_o), 0);
        end
        stallRun = 0;
        doneCount++;
      end
      if (bus_req_o) begin
        if (sb.size() == 0 || sb[0].isMis) begin
          nCompared++; nMismatched++;
          $display("[TB] FAIL req_unexpected: got bus_req 1, expected 0");
        end else begin
          checkOutput("bus_addr", bus_addr_o, sb[0].addr);
          checkOutput("bus_we", 32'(bus_we_o), 32'(sb[0].we));
          checkOutput("bus_wstrb", 32'(bus_wstrb_o), 32'(sb[0].wstrb));
          if (sb[0].we) checkOutput("bus_wdata", bus_wdata_o, sb[0].wdata);
        end
        checkOutput("err_in_wait", 32'(err_o), 0);
      end else if (prevReq) begin
        if (sb.size() == 0) begin
          nCompared++; nMismatched++;
          $display("[TB] FAIL done_unexpected: got completion, expected none");
        end else begin
          cur = sb.pop_front();
          checkOutput("done_err", 32'(err_o), 32'(cur.err));
          checkOutput("done_rdata", dram_rdata_o, cur.rdata);
          checkOutput("stall_cycles", 32'(stallRun), 32'(cur.stall));
          holdRdata = cur.rdata;
        end
        stallRun = 0;
        doneCount++;
      end else begin
        checkOutput("err_idle", 32'(err_o), 0);
        checkOutput("rdata_hold", dram_rdata_o, holdRdata);
      end
      prevReq = bus_req_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit          v, re, we, uns;
    logic [1:0]  sz;
    logic [31:0] addr, rs2, rdat;
    int          ack;
    rst_n_i = 1'b0; lateAck = 1'b0;
    valid_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10;
    mem_unsigned_i = 1'b0; alu_c_i = 32'h101; rs2_data_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    #3;
    checkOutput("reset_bus_req", 32'(bus_req_o), 0);
    checkOutput("reset_misalign", 32'(misalign_o), 0);
    checkOutput("reset_stall", 32'(stall_o), 0);
    checkOutput("reset_err", 32'(err_o), 0);
    checkOutput("reset_dram", dram_rdata_o, 0);
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    applyStimulus(1, 1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    checkOutput("lw_deadbeef", dram_rdata_o, 32'hDEADBEEF);
    applyStimulus(1, 1, 0, 2'b00, 0, 32'h103, 32'h0, 2, 32'h80123456);
    checkOutput("lb_signed", dram_rdata_o, 32'hFFFFFF80);
    applyStimulus(1, 1, 0, 2'b01, 1, 32'h102, 32'h0, 3, 32'h80123456);
    checkOutput("lhu", dram_rdata_o, 32'h00008012);
    applyStimulus(1, 0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 1, 32'h12345678);
    checkOutput("sh_keeps_rdata", dram_rdata_o, 32'h00008012);
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0);
    applyStimulus(1, 1, 0, 2'b11, 0, 32'h100, 32'h0, 1, 32'h0);
    applyStimulus(1, 1, 1, 2'b00, 0, 32'h305, 32'h0000005A, 4, 32'hFFFFFFFF);
    resetMidWait();
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'hCAFEF00D);
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h400, 32'h0, 0, 32'h0);
    checkOutput("timeout_dram", dram_rdata_o, 32'h0);

    for (int n = 0; n < 150; n++) begin
      v    = ($urandom_range(0, 7) != 0);
      re   = 1'($urandom);
      we   = 1'($urandom);
      sz   = 2'($urandom);
      uns  = 1'($urandom);
      addr = $urandom;
      rs2  = $urandom;
      rdat = $urandom;
      ack  = $urandom_range(0, 6);
      applyStimulus(v, re, we, sz, uns, addr, rs2, ack, rdat);
    end

    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
